// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution input loader.
package conv_pkg;
   localparam int WORD_W = 32;
   localparam int ROW_W  = 1024;
   localparam int ADDR_W = 8;
   localparam int WPR    = ROW_W / WORD_W;
   localparam int WIDX_W = $clog2(WPR);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/row_packer.sv
// Collects stream words into one BRAM row; slot k holds bits [k*WORD_W +: WORD_W].
module row_packer #(
   parameter int WORD_W = 32,
   parameter int ROW_W  = 1024,
   parameter int WIDX_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clear,
   input  logic              i_we,
   input  logic [WIDX_W-1:0] i_idx,
   input  logic [WORD_W-1:0] i_data,
   output logic [ROW_W-1:0]  o_row
);
   localparam int NSLOT = ROW_W / WORD_W;

   logic [WORD_W-1:0] r_slot [NSLOT];
   logic [NSLOT-1:0]  w_slot_we;

   always_comb begin
      w_slot_we = '0;
      if (i_we) w_slot_we = NSLOT'(1) << i_idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NSLOT; k++) r_slot[k] <= '0;
      end else begin
         for (int k = 0; k < NSLOT; k++) begin
            if (i_clear)           r_slot[k] <= '0;
            else if (w_slot_we[k]) r_slot[k] <= i_data;
         end
      end
   end

   for (genvar g = 0; g < NSLOT; g++) begin : g_row
      assign o_row[g*WORD_W +: WORD_W] = r_slot[g];
   end
endmodule

// File: rtl/conv_input_loader.sv
// Packs a valid/ready word stream into NUM_ROWS BRAM rows at addresses 0..NUM_ROWS-1.
module conv_input_loader #(
   parameter int WORD_W   = conv_pkg::WORD_W,
   parameter int ROW_W    = conv_pkg::ROW_W,
   parameter int ADDR_W   = conv_pkg::ADDR_W,
   parameter int NUM_ROWS = 130
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_start,
   input  logic                 load_abort,
   input  logic [WORD_W-1:0]    s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic                 ram_en,
   output logic                 ram_we,
   output logic [ADDR_W-1:0]    ram_addr,
   output logic [ROW_W-1:0]     ram_din,
   output logic                 load_busy,
   output logic                 load_done,
   output conv_pkg::state_t     dbg_state
);
   import conv_pkg::*;

   localparam int NWORDS = ROW_W / WORD_W;
   localparam int IW     = $clog2(NWORDS);

   state_t            r_state;
   logic [IW-1:0]     r_word_idx;
   logic [ADDR_W-1:0] r_row_idx;
   logic [ROW_W-1:0]  r_din_hold;
   logic [ROW_W-1:0]  w_row;
   logic              w_hs;
   logic              w_start;
   logic              w_clear;
   logic              w_pack_we;

   // s_ready is a registered state decode, so the handshake never loops through s_valid.
   assign w_hs      = s_valid & s_ready;
   assign w_start   = load_start & (((r_state == IDLE) & ~load_abort) | (r_state == DONE));
   assign w_clear   = w_start | ((r_state == FILL) & load_abort);
   assign w_pack_we = w_hs & ~load_abort;
   assign dbg_state = r_state;

   // The packer already holds the full row during WRITE; afterwards the held copy is shown.
   assign ram_din = (r_state == WRITE) ? w_row : r_din_hold;

   row_packer #(
      .WORD_W (WORD_W),
      .ROW_W  (ROW_W),
      .WIDX_W (IW)
   ) u_row_packer (
      .clk     (clk),
      .rst_n   (reset),
      .i_clear (w_clear),
      .i_we    (w_pack_we),
      .i_idx   (r_word_idx),
      .i_data  (s_data),
      .o_row   (w_row)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_word_idx <= '0;
         r_row_idx  <= '0;
         r_din_hold <= '0;
         s_ready    <= 1'b0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         load_busy  <= 1'b0;
         load_done  <= 1'b0;
      end else begin
         ram_en <= 1'b0;
         ram_we <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state    <= FILL;
                  r_word_idx <= '0;
                  r_row_idx  <= '0;
                  s_ready    <= 1'b1;
                  load_busy  <= 1'b1;
               end
            end
            FILL: begin
               if (load_abort) begin
                  r_state    <= IDLE;
                  r_word_idx <= '0;
                  s_ready    <= 1'b0;
                  load_busy  <= 1'b0;
               end else if (w_hs) begin
                  if (r_word_idx == IW'(NWORDS - 1)) begin
                     r_state    <= WRITE;
                     r_word_idx <= '0;
                     s_ready    <= 1'b0;
                     ram_en     <= 1'b1;
                     ram_we     <= 1'b1;
                     ram_addr   <= r_row_idx;
                  end else begin
                     r_word_idx <= r_word_idx + 1'b1;
                  end
               end
            end
            WRITE: begin
               r_din_hold <= w_row;
               if (load_abort) begin
                  r_state   <= IDLE;
                  load_busy <= 1'b0;
               end else if (r_row_idx == ADDR_W'(NUM_ROWS - 1)) begin
                  r_state   <= DONE;
                  load_busy <= 1'b0;
                  load_done <= 1'b1;
               end else begin
                  r_row_idx <= r_row_idx + 1'b1;
                  r_state   <= FILL;
                  s_ready   <= 1'b1;
               end
            end
            DONE: begin
               if (w_start) begin
                  r_state    <= FILL;
                  r_word_idx <= '0;
                  r_row_idx  <= '0;
                  s_ready    <= 1'b1;
                  load_busy  <= 1'b1;
                  load_done  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_input_loader.sv
// Bench for conv_input_loader: a 2-row instance for protocol scenarios and a 256-row instance for the address limit.
module tb_conv_input_loader;
   import conv_pkg::*;

   localparam int WORD_W = 32;
   localparam int ROW_W  = 1024;
   localparam int ADDR_W = 8;
   localparam int WPR    = ROW_W / WORD_W;
   localparam int NR     = 2;
   localparam int NRB    = 256;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // small instance
   logic              load_start = 0, load_abort = 0, s_valid = 0;
   logic [WORD_W-1:0] s_data = '0;
   logic              s_ready, ram_en, ram_we, load_busy, load_done;
   logic [ADDR_W-1:0] ram_addr;
   logic [ROW_W-1:0]  ram_din;
   state_t            dbg_state;

   conv_input_loader #(.WORD_W(WORD_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W), .NUM_ROWS(NR)) u_dut (
      .clk(clk), .reset(rst_n), .load_start(load_start), .load_abort(load_abort),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .ram_en(ram_en), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_din(ram_din), .load_busy(load_busy), .load_done(load_done),
      .dbg_state(dbg_state)
   );

   // large instance
   logic              b_load_start = 0, b_load_abort = 0, b_s_valid = 0;
   logic [WORD_W-1:0] b_s_data = '0;
   logic              b_s_ready, b_ram_en, b_ram_we, b_load_busy, b_load_done;
   logic [ADDR_W-1:0] b_ram_addr;
   logic [ROW_W-1:0]  b_ram_din;
   state_t            b_dbg_state;

   conv_input_loader #(.WORD_W(WORD_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W), .NUM_ROWS(NRB)) u_dut_big (
      .clk(clk), .reset(rst_n), .load_start(b_load_start), .load_abort(b_load_abort),
      .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready), .ram_en(b_ram_en), .ram_we(b_ram_we),
      .ram_addr(b_ram_addr), .ram_din(b_ram_din), .load_busy(b_load_busy), .load_done(b_load_done),
      .dbg_state(b_dbg_state)
   );

   // reference model: rows are consecutive groups of WPR accepted words, addresses count from 0 per load
   logic [ROW_W-1:0]  exp_q[$];
   logic [ADDR_W-1:0] exp_addr_q[$];
   logic [ROW_W-1:0]  m_row, m_last_row;
   int                m_idx, m_rows;
   int                t0;

   function automatic void model_start();
      m_idx = 0; m_rows = 0; m_row = '0;
   endfunction

   function automatic void model_abort();
      m_idx = 0; m_row = '0;
   endfunction

   function automatic void model_accept(input logic [WORD_W-1:0] w);
      m_row[m_idx*WORD_W +: WORD_W] = w;
      m_idx++;
      if (m_idx == WPR) begin
         exp_q.push_back(m_row);
         exp_addr_q.push_back(ADDR_W'(m_rows));
         m_last_row = m_row;
         m_rows++;
         m_idx = 0;
         m_row = '0;
      end
   endfunction

   function automatic int first_diff(input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b);
      for (int k = 0; k < WPR; k++)
         if (a[k*WORD_W +: WORD_W] !== b[k*WORD_W +: WORD_W]) return k;
      return -1;
   endfunction

   // scoreboard on the small instance's BRAM port
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (s_ready && !load_busy) begin
            errors++; $display("FAIL ready_outside_busy: s_ready=1 load_busy=0 at cycle %0d", cyc);
         end
         if (ram_we) begin
            checks++;
            if (!ram_en || s_ready) begin
               errors++; $display("FAIL write_strobe: ram_en=%0b s_ready=%0b, required 1 and 0", ram_en, s_ready);
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL unexpected_write: addr=%0d with no row expected", ram_addr);
            end else begin
               logic [ROW_W-1:0]  ed;
               logic [ADDR_W-1:0] ea;
               int                d;
               ed = exp_q.pop_front();
               ea = exp_addr_q.pop_front();
               d  = first_diff(ram_din, ed);
               if (ram_addr !== ea || d >= 0) begin
                  errors++;
                  if (d < 0) d = 0;
                  $display("FAIL ram_write: addr got %0d exp %0d, word %0d got %h exp %h",
                           ram_addr, ea, d, ram_din[d*WORD_W +: WORD_W], ed[d*WORD_W +: WORD_W]);
               end
            end
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk); @(negedge clk);
   endtask

   task automatic start_load();
      checks++;
      if (s_ready !== 1'b0) begin
         errors++; $display("FAIL ready_before_start: s_ready got %0b exp 0", s_ready);
      end
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      t0 = cyc;
      model_start();
      checks++;
      if (s_ready !== 1'b1 || load_busy !== 1'b1) begin
         errors++; $display("FAIL ready_after_start: s_ready=%0b load_busy=%0b exp 1 1", s_ready, load_busy);
      end
   endtask

   task automatic drive_stream(input int n, input int pct, input bit seq, input int start_at);
      int got = 0;
      int guard = 0;
      logic [WORD_W-1:0] w;
      w = seq ? '0 : $urandom;
      while (got < n && guard < 5000) begin
         s_valid    = ($urandom_range(99) < pct);
         s_data     = w;
         load_start = (got == start_at);
         if (s_valid && s_ready) begin
            model_accept(w);
            got++;
            w = seq ? WORD_W'(got) : $urandom;
         end
         step();
         guard++;
      end
      s_valid = 1'b0;
      load_start = 1'b0;
      checks++;
      if (got != n) begin
         errors++; $display("FAIL stream_timeout: accepted %0d words, required %0d", got, n);
      end
   endtask

   task automatic wait_done();
      int g = 0;
      while (!load_done && g < 300) begin step(); g++; end
      checks++;
      if (load_done !== 1'b1 || load_busy !== 1'b0 || s_ready !== 1'b0) begin
         errors++; $display("FAIL done_state: load_done=%0b load_busy=%0b s_ready=%0b exp 1 0 0",
                            load_done, load_busy, s_ready);
      end
   endtask

   task automatic check_drained(input string tag);
      step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL %s_rows_missing: %0d rows not written", tag, exp_q.size());
      end
   endtask

   // tests
   task automatic test_reset();
      repeat (3) step();
      checks++;
      if ({s_ready, ram_en, ram_we, load_busy, load_done} !== 5'b0 || ram_addr !== '0 ||
          ram_din !== '0 || dbg_state !== IDLE) begin
         errors++; $display("FAIL reset_values: ready=%0b en=%0b we=%0b busy=%0b done=%0b addr=%0d state=%0d",
                            s_ready, ram_en, ram_we, load_busy, load_done, ram_addr, dbg_state);
      end
      rst_n = 1'b1;
      repeat (2) step();
      checks++;
      if (dbg_state !== IDLE || s_ready !== 1'b0) begin
         errors++; $display("FAIL reset_release_idle: state=%0d s_ready=%0b exp IDLE 0", dbg_state, s_ready);
      end
   endtask

   task automatic test_basic();
      start_load();
      drive_stream(2 * WPR, 100, 1'b1, -1);
      wait_done();
      checks++;
      if (cyc - t0 != NR * (WPR + 1)) begin
         errors++; $display("FAIL done_latency: load_done after 1+%0d cycles, exp 1+%0d", cyc - t0, NR * (WPR + 1));
      end
      check_drained("basic");
      s_valid = 1'b1;
      repeat (3) step();
      s_valid = 1'b0;
      checks++;
      if (ram_en !== 1'b0 || ram_addr !== ADDR_W'(NR - 1) || ram_din !== m_last_row || load_done !== 1'b1) begin
         errors++; $display("FAIL hold_after_done: en=%0b addr=%0d done=%0b exp 0 %0d 1 (data held=%0b)",
                            ram_en, ram_addr, load_done, NR - 1, ram_din === m_last_row);
      end
   endtask

   task automatic test_start_while_busy();
      start_load();
      checks++;
      if (load_done !== 1'b0) begin
         errors++; $display("FAIL restart_done_clear: load_done got %0b exp 0", load_done);
      end
      drive_stream(2 * WPR, 100, 1'b0, 40);
      wait_done();
      checks++;
      if (cyc - t0 != NR * (WPR + 1)) begin
         errors++; $display("FAIL busy_start_latency: 1+%0d cycles, exp 1+%0d", cyc - t0, NR * (WPR + 1));
      end
      check_drained("busy_start");
   endtask

   task automatic test_backpressure();
      start_load();
      drive_stream(2 * WPR, 40, 1'b0, -1);
      wait_done();
      checks++;
      if (cyc - t0 <= NR * (WPR + 1)) begin
         errors++; $display("FAIL backpressure_latency: %0d cycles, exp more than %0d", cyc - t0, NR * (WPR + 1));
      end
      check_drained("backpressure");
   endtask

   task automatic test_abort();
      load_abort = 1'b1;
      step();
      load_abort = 1'b0;
      checks++;
      if (load_done !== 1'b1 || dbg_state !== DONE) begin
         errors++; $display("FAIL abort_in_done: load_done=%0b state=%0d exp 1 DONE", load_done, dbg_state);
      end
      start_load();
      drive_stream(WPR + 10, 100, 1'b0, -1);
      load_abort = 1'b1;
      s_valid    = 1'b1;
      s_data     = $urandom;
      step();
      load_abort = 1'b0;
      s_valid    = 1'b0;
      model_abort();
      checks++;
      if (dbg_state !== IDLE || load_busy !== 1'b0 || s_ready !== 1'b0) begin
         errors++; $display("FAIL abort_in_fill: state=%0d busy=%0b ready=%0b exp IDLE 0 0",
                            dbg_state, load_busy, s_ready);
      end
      repeat (4) step();
      check_drained("abort");
      load_start = 1'b1;
      load_abort = 1'b1;
      step();
      load_start = 1'b0;
      load_abort = 1'b0;
      checks++;
      if (dbg_state !== IDLE || s_ready !== 1'b0) begin
         errors++; $display("FAIL abort_priority: state=%0d s_ready=%0b exp IDLE 0", dbg_state, s_ready);
      end
      start_load();
      drive_stream(2 * WPR, 100, 1'b0, -1);
      wait_done();
      check_drained("after_abort");
   endtask

   task automatic test_abort_in_write();
      start_load();
      drive_stream(WPR, 100, 1'b0, -1);
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== '0) begin
         errors++; $display("FAIL write_after_32: ram_we=%0b addr=%0d exp 1 0", ram_we, ram_addr);
      end
      load_abort = 1'b1;
      step();
      load_abort = 1'b0;
      model_abort();
      checks++;
      if (dbg_state !== IDLE || load_busy !== 1'b0 || load_done !== 1'b0) begin
         errors++; $display("FAIL abort_in_write: state=%0d busy=%0b done=%0b exp IDLE 0 0",
                            dbg_state, load_busy, load_done);
      end
      check_drained("abort_write");
   endtask

   task automatic test_reset_mid_fill();
      start_load();
      drive_stream(5, 100, 1'b0, -1);
      rst_n = 1'b0;
      #1;
      model_abort();
      checks++;
      if ({s_ready, ram_en, ram_we, load_busy, load_done} !== 5'b0 || ram_addr !== '0 ||
          ram_din !== '0 || dbg_state !== IDLE) begin
         errors++; $display("FAIL async_reset: ready=%0b en=%0b we=%0b busy=%0b done=%0b addr=%0d state=%0d",
                            s_ready, ram_en, ram_we, load_busy, load_done, ram_addr, dbg_state);
      end
      @(negedge clk);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (3) step();
      checks++;
      if (dbg_state !== IDLE || s_ready !== 1'b0 || ram_we !== 1'b0) begin
         errors++; $display("FAIL reset_mid_fill_idle: state=%0d ready=%0b we=%0b exp IDLE 0 0",
                            dbg_state, s_ready, ram_we);
      end
      check_drained("reset");
   endtask

   task automatic test_num_rows_256();
      logic [ROW_W-1:0] bq[$];
      logic [ROW_W-1:0] brow, ed;
      logic [WORD_W-1:0] w;
      int bidx = 0;
      int nwr  = 0;
      int last_addr = -1;
      int g = 0;
      int bt0;
      brow = '0;
      w = $urandom;
      b_load_start = 1'b1;
      step();
      b_load_start = 1'b0;
      bt0 = cyc;
      while (!b_load_done && g < 9000) begin
         b_s_valid = 1'b1;
         b_s_data  = w;
         if (b_ram_we) begin
            checks++;
            if (bq.size() == 0) begin
               errors++; $display("FAIL big_unexpected_write: addr=%0d", b_ram_addr);
            end else begin
               ed = bq.pop_front();
               if (b_ram_addr !== ADDR_W'(nwr) || b_ram_din !== ed) begin
                  errors++; $display("FAIL big_write: addr got %0d exp %0d, data match=%0b",
                                     b_ram_addr, nwr, b_ram_din === ed);
               end
            end
            last_addr = int'(b_ram_addr);
            nwr++;
         end
         if (b_s_ready) begin
            brow[bidx*WORD_W +: WORD_W] = w;
            bidx++;
            if (bidx == WPR) begin bq.push_back(brow); bidx = 0; brow = '0; end
            w = $urandom;
         end
         step();
         g++;
      end
      b_s_valid = 1'b0;
      checks++;
      if (b_load_done !== 1'b1 || nwr != NRB || last_addr != NRB - 1) begin
         errors++; $display("FAIL big_load: done=%0b writes=%0d last_addr=%0d exp 1 %0d %0d",
                            b_load_done, nwr, last_addr, NRB, NRB - 1);
      end
      checks++;
      if (cyc - bt0 != NRB * (WPR + 1)) begin
         errors++; $display("FAIL big_latency: 1+%0d cycles, exp 1+%0d", cyc - bt0, NRB * (WPR + 1));
      end
      step();
      checks++;
      if (b_ram_addr !== ADDR_W'(NRB - 1) || b_ram_en !== 1'b0) begin
         errors++; $display("FAIL big_addr_hold: addr=%0d en=%0b exp %0d 0", b_ram_addr, b_ram_en, NRB - 1);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_start_while_busy();
      test_backpressure();
      test_abort();
      test_abort_in_write();
      test_reset_mid_fill();
      test_num_rows_256();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
